// File: rtl/sensor_sink_ni.sv
// Receive-side NI for sensor flit streams: queues priority events for the sink core
// and assembles checksummed sample packets into a 16-entry sample table.
module sensor_sink_ni #(
    parameter int unsigned PRIO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_req,
    input  logic [15:0] input_data,
    output logic        input_bussy,
    output logic        irq_valid,
    output logic [3:0]  irq_src,
    output logic [3:0]  irq_sensor,
    input  logic        irq_ack,
    input  logic [3:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        update_valid,
    output logic [15:0] update_mask,
    output logic [3:0]  update_src,
    output logic [7:0]  err_count
);

    localparam int unsigned PW = (PRIO_DEPTH > 1) ? $clog2(PRIO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(PRIO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     src_q;
    logic [4:0]     remaining_q;
    logic [15:0]    mask_q;
    logic [7:0]     sum_q;
    logic [7:0]     shadow_q [16];
    logic [7:0]     table_q  [16];
    logic [7:0]     rd_data_q;
    logic           update_valid_q;
    logic [15:0]    update_mask_q;
    logic [3:0]     update_src_q;
    logic [7:0]     err_q;

    logic [7:0]     prio_mem_q [PRIO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           bussy_q, irq_valid_q;

    logic           accept_s, push_s, pop_s;
    logic           is_prio_s, is_head_s, is_body_s, is_tail_s;
    logic           start_s, body_s, commit_s, err_s;

    assign accept_s  = input_req & ~bussy_q;
    assign is_prio_s = (input_data[15:13] == 3'b111);
    assign is_head_s = (input_data[15:13] == 3'b100);
    assign is_body_s = (input_data[15:13] == 3'b000);
    assign is_tail_s = (input_data[15:13] == 3'b110);
    assign push_s    = accept_s & is_prio_s;
    assign pop_s     = irq_ack & (count_q != {CW{1'b0}});

    // Queue occupancy next state; push is blocked by bussy so it never overflows
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_s) begin
            count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Priority event FIFO storage, pointers and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PRIO_DEPTH); i++) begin
                prio_mem_q[i] <= 8'h00;
            end
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            bussy_q     <= 1'b0;
            irq_valid_q <= 1'b0;
        end else begin
            if (push_s) begin
                prio_mem_q[wr_ptr_q] <= {input_data[12:9], input_data[3:0]};
                wr_ptr_q             <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            end
            count_q     <= count_d;
            bussy_q     <= (count_d == FULL_CNT);
            irq_valid_q <= (count_d != {CW{1'b0}});
        end
    end

    // Packet assembly FSM; priority flits bypass it entirely
    always_comb begin
        state_d  = state_q;
        start_s  = 1'b0;
        body_s   = 1'b0;
        commit_s = 1'b0;
        err_s    = 1'b0;
        if (accept_s && !is_prio_s) begin
            case (state_q)
                IDLE: begin
                    if (is_head_s) begin
                        start_s = 1'b1;
                        state_d = BODY;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                BODY: begin
                    if (is_body_s) begin
                        body_s  = 1'b1;
                        state_d = (remaining_q == 5'd1) ? TAIL : BODY;
                    end else if (is_head_s) begin
                        err_s   = 1'b1;
                        start_s = 1'b1;
                        state_d = BODY;
                    end else begin
                        err_s   = 1'b1;
                        state_d = IDLE;
                    end
                end
                TAIL: begin
                    if (is_tail_s) begin
                        commit_s = (input_data[7:0] == sum_q);
                        err_s    = (input_data[7:0] != sum_q);
                        state_d  = IDLE;
                    end else if (is_head_s) begin
                        err_s   = 1'b1;
                        start_s = 1'b1;
                        state_d = BODY;
                    end else begin
                        err_s   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Assembly datapath, sample table, commit reporting and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            src_q          <= 4'h0;
            remaining_q    <= 5'd0;
            mask_q         <= 16'h0000;
            sum_q          <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= 8'h00;
                table_q[i]  <= 8'h00;
            end
            rd_data_q      <= 8'h00;
            update_valid_q <= 1'b0;
            update_mask_q  <= 16'h0000;
            update_src_q   <= 4'h0;
            err_q          <= 8'h00;
        end else begin
            state_q   <= state_d;
            rd_data_q <= table_q[rd_addr];
            if (start_s) begin
                src_q       <= input_data[12:9];
                remaining_q <= {1'b0, input_data[3:0]} + 5'd1;
                mask_q      <= 16'h0000;
                sum_q       <= 8'h00;
            end else if (body_s) begin
                shadow_q[input_data[11:8]] <= input_data[7:0];
                mask_q[input_data[11:8]]   <= 1'b1;
                sum_q       <= sum_q + input_data[7:0];
                remaining_q <= remaining_q - 5'd1;
            end
            // Table write and mask capture share the edge that accepts the tail
            if (commit_s) begin
                for (int i = 0; i < 16; i++) begin
                    if (mask_q[i]) begin
                        table_q[i] <= shadow_q[i];
                    end
                end
                update_mask_q <= mask_q;
                update_src_q  <= src_q;
            end
            update_valid_q <= commit_s;
            if (err_s && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign input_bussy  = bussy_q;
    assign irq_valid    = irq_valid_q;
    assign irq_src      = prio_mem_q[rd_ptr_q][7:4];
    assign irq_sensor   = prio_mem_q[rd_ptr_q][3:0];
    assign rd_data      = rd_data_q;
    assign update_valid = update_valid_q;
    assign update_mask  = update_mask_q;
    assign update_src   = update_src_q;
    assign err_count    = err_q;

endmodule
